decoder_cfg_sequencer: RTL
==========================

# decoder_cfg_sequencer

Register-bus master that configures, starts, runs and stops one `Decoder` instance. The host queues filter, arith and decider coefficient writes into a small FIFO, then pulses `go`. The sequencer then:
- halts the datapath,
- replays the queued writes onto the decoder's `writ`/`address`/`data` bus,
- enables and starts the datapath,
- holds `work` for a fixed measurement window while counting `indicate` rising edges,
- shuts the datapath down.

## Interface
- `DEPTH`, 8: command FIFO entries (power of two, ≥2).
- `RUN_CYCLES`, 50_000: measurement window length in clk cycles (≥1, fits 32 bits).
- `SETTLE_CYCLES`, 64: post-start settle delay (used only with the macro; ≥1).
- `CNT_W`, 16: width of `hit_count`.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset_l`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  host offers a config entry.
- `cmd_ready`  out  1  entry accepted when `cmd_valid & cmd_ready`.
- `cmd_addr`  in  5  decoder address: [4:3] block, [2:0] register.
- `cmd_data`  in  32  decoder write data.
- `go`  in  1  start sequence (level sampled; only acts in IDLE).
- `abort`  in  1  terminate sequence.
- `dec_writ`  out  1  decoder write strobe.
- `dec_address`  out  5  decoder address.
- `dec_data`  out  32  decoder write data.
- `dec_work`  out  1  decoder `work` input.
- `indicate_i`  in  1  decoder `indicate` (synchronous to clk).
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse in STOP.
- `err_ctrl`  out  1  sticky: a queued entry targeted block 00; cleared on accepted `go`.
- `hit_count`  out  CNT_W  `indicate_i` rising edges in the last run, saturating.

## Operation
- Control-register word (address 5'b00000): bit0 = clk_en, bit1 = start, bit2 = enabel; bits [31:3] are 0. Only the sequencer drives block 00.
- Reset: state IDLE, FIFO empty, all registered outputs 0 (`dec_*`, `busy`, `done`, `err_ctrl`, `hit_count`). `cmd_ready` = (state==IDLE) & !full, so it reads 1 during and after reset.
- States and transitions:
  - **IDLE**: on `go`, clear `hit_count` and `err_ctrl`, then go to HALT.
  - **HALT** (1 cycle): write ctrl = 0. Next state is LOAD if the FIFO is non-empty, else ARM.
  - **LOAD**: pop one entry per cycle.
    - If addr[4:3] ≠ 00, drive `dec_writ`=1 with that addr/data.
    - If addr[4:3] = 00, hold `dec_writ`=0, drop the entry and set `err_ctrl`.
    - When the last entry is popped, go to ARM.
  - **ARM** (1 cycle): write ctrl = 3'b101.
  - **START** (1 cycle): write ctrl = 3'b111.
  - **RUN**: `dec_work`=1 for RUN_CYCLES cycles, then go to STOP. During RUN, `hit_count` increments when `indicate_i` & !`indicate_q`, saturating at all-ones. `indicate_q` is `indicate_i` delayed one cycle and updates every cycle.
  - **STOP** (1 cycle): write ctrl = 0, `dec_work`=0, `done`=1, then go to IDLE.
- Abort:
  - In HALT, LOAD, ARM, START or RUN (and SETTLE with the macro), the next state is STOP. The FIFO is flushed in that same transition.
  - `hit_count` keeps its partial value.
  - Abort in IDLE or STOP is ignored.
- `go` outside IDLE is ignored. `go` and `abort` together in IDLE: `go` wins.
- A push and `go` in the same IDLE cycle: the entry is accepted and included in the load.

## Timing
- All `dec_*`, `busy`, `done` and `hit_count` outputs are registered. `dec_writ` is 0 in every cycle not listed above.
- With `go` sampled at edge t and N queued entries:
  - HALT write is visible in cycle t+1.
  - LOAD writes occupy t+2 … t+1+N.
  - ARM is at t+2+N and START at t+3+N.
  - `dec_work`=1 over t+4+N … t+3+N+RUN_CYCLES.
  - STOP/`done` is at t+4+N+RUN_CYCLES.
- An abort sampled at edge a produces STOP in cycle a+1.
- A reset assertion mid-run forces IDLE with all outputs 0 asynchronously. No ctrl=0 write is issued; the decoder is reset by the same `reset_l`.

## Configuration
- `CFG_SEQ_SETTLE_EN` defined: a SETTLE state is inserted between START and RUN.
  - Lasts SETTLE_CYCLES cycles with `dec_work`=0 and no writes.
  - Lets the filter pipelines flush.
  - RUN starts SETTLE_CYCLES cycles later than the undefined case.
- `CFG_SEQ_SETTLE_EN` undefined: no SETTLE state; RUN follows START directly and the SETTLE_CYCLES parameter is unused.

## Structure
- `cfg_seq_pkg` contains:
  - the state enum;
  - ctrl bit positions (CLK_EN=0, START=1, ENABEL=2);
  - block select codes (CTRL=2'b00, FILTR=2'b01, ARITH=2'b10, DECIDER=2'b11);
  - the ctrl words HALT=32'h0, ARM=32'h5, START=32'h7.
- Sub-module `cfg_seq_fifo`: synchronous FIFO, DEPTH × 37 bits, with push/pop/flush and full/empty, reset to empty.

## Test plan
- Queue {5'h08,32'h11}, {5'h11,32'h22}, {5'h19,32'h33}, pulse `go`, RUN_CYCLES=10 → bus sequence {00,0}, {08,11}, {11,22}, {19,33}, {00,5}, {00,7}; `dec_work` high exactly 10 cycles; ctrl {00,0} with `done` in the next cycle.
- Empty FIFO plus `go` → HALT, ARM and START in consecutive cycles; no LOAD writes.
- Queue {5'h03,32'hFF}, {5'h08,32'h1}, `go` → `err_ctrl`=1; only {08,1} appears between HALT and ARM, and that LOAD cycle is preceded by one `dec_writ`=0 cycle.
- Pulse `indicate_i` 3 times in RUN and 2 times outside it → `hit_count`=3. With CNT_W=2 and 5 pulses in RUN → `hit_count`=3 (saturated).
- `abort` in the 5th RUN cycle → STOP next cycle with ctrl=0 and `done`; FIFO empty; `cmd_ready`=1 once back in IDLE.
- Fill DEPTH entries → `cmd_ready`=0. Assert `reset_l`=0 mid-LOAD → all outputs 0 immediately, FIFO empty.

Source files
------------

// File: rtl/cfg_seq_pkg.sv
// Shared types and constants for the decoder configuration sequencer:
// state encoding, control-register layout, block select codes and the
// command entry carried through the FIFO.
package cfg_seq_pkg;

  // Sequencer states; ST_SETTLE is only reachable when CFG_SEQ_SETTLE_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HALT   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_ARM    = 3'd3,
    ST_START  = 3'd4,
    ST_SETTLE = 3'd5,
    ST_RUN    = 3'd6,
    ST_STOP   = 3'd7
  } state_e;

  // Bit positions inside the decoder control register.
  localparam int unsigned CTRL_BIT_CLK_EN = 0;
  localparam int unsigned CTRL_BIT_START  = 1;
  localparam int unsigned CTRL_BIT_ENABEL = 2;

  // Block select codes carried in address bits [4:3].
  localparam logic [1:0] BLK_CTRL    = 2'b00;
  localparam logic [1:0] BLK_FILTR   = 2'b01;
  localparam logic [1:0] BLK_ARITH   = 2'b10;
  localparam logic [1:0] BLK_DECIDER = 2'b11;

  // The control register lives at the bottom of block 00.
  localparam logic [4:0] CTRL_ADDR = {BLK_CTRL, 3'b000};

  // Control words written by the sequencer itself.
  localparam logic [31:0] CTRL_WORD_HALT  = 32'h0;
  localparam logic [31:0] CTRL_WORD_ARM   = (32'd1 << CTRL_BIT_ENABEL)
                                          | (32'd1 << CTRL_BIT_CLK_EN);
  localparam logic [31:0] CTRL_WORD_START = CTRL_WORD_ARM
                                          | (32'd1 << CTRL_BIT_START);

  // One queued configuration write.
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  // True when the entry addresses a block the host is allowed to write.
  function automatic logic is_host_block(input logic [4:0] addr);
    return addr[4:3] inside {BLK_FILTR, BLK_ARITH, BLK_DECIDER};
  endfunction

endpackage

// File: rtl/cfg_seq_fifo.sv
// Synchronous command FIFO for the configuration sequencer.
// DEPTH entries of cmd_t, push/pop/flush, full/empty flags, resets empty.
// The head entry is presented combinationally on rdata_o.
module cfg_seq_fifo
  import cfg_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic reset_l,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  cmd_t wdata_i,
  output cmd_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Pointer advance; a flush discards everything queued.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge reset_l) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (!reset_l) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    if (push_ok && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/decoder_cfg_sequencer.sv
// Register-bus master that halts, configures, starts, runs and stops one
// Decoder instance. Host writes are queued in cfg_seq_fifo and replayed on
// go; the run window counts indicate_i rising edges into hit_count.
// Optional macro CFG_SEQ_SETTLE_EN inserts a SETTLE_CYCLES-long settle state
// between START and RUN so the filter pipelines can flush.
module decoder_cfg_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned RUN_CYCLES    = 50_000,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic              go,
  input  logic              abort,
  output logic              dec_writ,
  output logic [4:0]        dec_address,
  output logic [31:0]       dec_data,
  output logic              dec_work,
  input  logic              indicate_i,
  output logic              busy,
  output logic              done,
  output logic              err_ctrl,
  output logic [CNT_W-1:0]  hit_count
);

  // One timer serves both the run window and the optional settle delay.
  localparam int unsigned TMR_MAX = (RUN_CYCLES > SETTLE_CYCLES) ? RUN_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] RUN_LAST = TMR_W'(RUN_CYCLES - 1);
`ifdef CFG_SEQ_SETTLE_EN
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
`endif

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               indicate_q;

  logic               dec_writ_q, dec_writ_d;
  logic [4:0]         dec_address_q, dec_address_d;
  logic [31:0]        dec_data_q, dec_data_d;
  logic               dec_work_q, dec_work_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_ctrl_q, err_ctrl_d;
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;

  cmd_t               fifo_wdata, fifo_head;
  logic               fifo_push, fifo_pop, fifo_flush;
  logic               fifo_full, fifo_empty;
  logic               abort_ok, go_ok;

  assign go_ok     = (state_q == ST_IDLE) & go;
  assign abort_ok  = abort & (state_q inside {ST_HALT, ST_LOAD, ST_ARM, ST_START, ST_SETTLE, ST_RUN});
  assign cmd_ready = (state_q == ST_IDLE) & ~fifo_full;

  assign fifo_wdata = '{addr: cmd_addr, data: cmd_data};
  assign fifo_push  = cmd_valid & cmd_ready;
  assign fifo_pop   = (state_d == ST_LOAD);
  assign fifo_flush = abort_ok;

  cfg_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_l (reset_l),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State and timer registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      indicate_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      indicate_q <= indicate_i;
    end
  end

  // Next-state logic; an abort in any active state overrides to STOP.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE:  if (go) state_d = ST_HALT;
      ST_HALT:  state_d = fifo_empty ? ST_ARM : ST_LOAD;
      ST_LOAD:  state_d = fifo_empty ? ST_ARM : ST_LOAD;
      ST_ARM:   state_d = ST_START;
      ST_START: begin
        tmr_d = '0;
`ifdef CFG_SEQ_SETTLE_EN
        state_d = ST_SETTLE;
`else
        state_d = ST_RUN;
`endif
      end
`ifdef CFG_SEQ_SETTLE_EN
      ST_SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
`endif
      ST_RUN: begin
        if (tmr_q == RUN_LAST) state_d = ST_STOP;
        else                   tmr_d   = tmr_q + TMR_W'(1);
      end
      ST_STOP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_ok) state_d = ST_STOP;
  end

  // Output logic: bus values are derived from the state being entered so
  // they appear, registered, in that state's cycle.
  always_comb begin
    dec_writ_d    = 1'b0;
    dec_address_d = '0;
    dec_data_d    = '0;
    dec_work_d    = 1'b0;
    done_d        = 1'b0;
    busy_d        = (state_d != ST_IDLE);
    err_ctrl_d    = err_ctrl_q;
    hit_count_d   = hit_count_q;

    if (go_ok) begin
      err_ctrl_d  = 1'b0;
      hit_count_d = '0;
    end
    if ((state_q == ST_RUN) && indicate_i && !indicate_q && !(&hit_count_q)) begin
      hit_count_d = hit_count_q + 1'b1;
    end

    case (state_d)
      ST_HALT: begin
        dec_writ_d    = 1'b1;
        dec_address_d = CTRL_ADDR;
        dec_data_d    = CTRL_WORD_HALT;
      end
      ST_LOAD: begin
        if (is_host_block(fifo_head.addr)) begin
          dec_writ_d    = 1'b1;
          dec_address_d = fifo_head.addr;
          dec_data_d    = fifo_head.data;
        end else begin
          err_ctrl_d = 1'b1;
        end
      end
      ST_ARM: begin
        dec_writ_d    = 1'b1;
        dec_address_d = CTRL_ADDR;
        dec_data_d    = CTRL_WORD_ARM;
      end
      ST_START: begin
        dec_writ_d    = 1'b1;
        dec_address_d = CTRL_ADDR;
        dec_data_d    = CTRL_WORD_START;
      end
      ST_RUN: dec_work_d = 1'b1;
      ST_STOP: begin
        dec_writ_d    = 1'b1;
        dec_address_d = CTRL_ADDR;
        dec_data_d    = CTRL_WORD_HALT;
        done_d        = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs, all zero under reset.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      dec_writ_q    <= 1'b0;
      dec_address_q <= '0;
      dec_data_q    <= '0;
      dec_work_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_ctrl_q    <= 1'b0;
      hit_count_q   <= '0;
    end else begin
      dec_writ_q    <= dec_writ_d;
      dec_address_q <= dec_address_d;
      dec_data_q    <= dec_data_d;
      dec_work_q    <= dec_work_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_ctrl_q    <= err_ctrl_d;
      hit_count_q   <= hit_count_d;
    end
  end

  assign dec_writ    = dec_writ_q;
  assign dec_address = dec_address_q;
  assign dec_data    = dec_data_q;
  assign dec_work    = dec_work_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_ctrl    = err_ctrl_q;
  assign hit_count   = hit_count_q;

endmodule
